// File: rtl/hdr_cksum_engine.sv
// -----------------------------------------------------------------------------
// hdr_cksum_engine
//
// Computes the 16-bit ones-complement Internet checksum over a byte span of
// the in-flight packet header. It is the responder side of the executor's
// checksum handshake. The engine reads the executor's header array live and
// adds two bytes per clock (a big-endian word). When the span is done, it
// folds the 32-bit accumulator and reports the complemented result with a
// one-cycle ready pulse.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start_i        request strobe, only looked at while idle
//   pkt_hdr_i      header bytes, element 0 is first on the wire
//   field_start_i  first byte index of the span
//   field_len_i    span length in bytes (clamped to HDR_MAX_LEN)
//   cksum_ready_o  one-cycle pulse, cksum_val_o carries a fresh result
//   cksum_val_o    checksum result, held until the next result
// -----------------------------------------------------------------------------
module hdr_cksum_engine #(
  parameter int HDR_MAX_LEN = 64,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]    pkt_hdr_i,
  input  logic [ADDR_W-1:0]              field_start_i,
  input  logic [LEN_W-1:0]               field_len_i,
  output logic                           cksum_ready_o,
  output logic [15:0]                    cksum_val_o
);

  localparam int IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
  localparam int REM_W = $clog2(HDR_MAX_LEN + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FOLD = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        acc, acc_nxt;
  logic [ADDR_W-1:0]  ptr, ptr_nxt;
  logic [REM_W-1:0]   rem, rem_nxt;
  logic               ready_nxt;
  logic [15:0]        val_nxt;
  logic [REM_W-1:0]   len_clamp;
  logic [7:0]         byte_hi;
  logic [7:0]         byte_lo;

  // Bytes outside the header buffer read as zero. This includes indices
  // reached when ptr wraps.
  function automatic logic [7:0] hdr_byte(
    input logic [HDR_MAX_LEN-1:0][7:0] hdr,
    input logic [ADDR_W-1:0]           idx
  );
    logic [7:0] b;
    if (idx >= ADDR_W'(HDR_MAX_LEN)) b = 8'h00;
    else                             b = hdr[idx[IDX_W-1:0]];
    return b;
  endfunction

  // Fold the carries twice. The second add can carry at most once more, and
  // that carry cannot ripple out again.
  function automatic logic [15:0] fold_cksum(input logic [31:0] a);
    logic [16:0] s;
    s = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    s = {1'b0, s[15:0]} + {16'h0000, s[16]};
    return ~s[15:0];
  endfunction

  assign len_clamp = (field_len_i > LEN_W'(HDR_MAX_LEN)) ? REM_W'(HDR_MAX_LEN)
                                                        : REM_W'(field_len_i);

  // On an odd tail only one byte is left. The missing low byte pads as zero.
  assign byte_hi = hdr_byte(pkt_hdr_i, ptr);
  assign byte_lo = (rem >= REM_W'(2)) ? hdr_byte(pkt_hdr_i, ptr + ADDR_W'(1)) : 8'h00;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ptr_nxt   = ptr;
    rem_nxt   = rem;
    ready_nxt = 1'b0;
    val_nxt   = cksum_val_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          ptr_nxt   = field_start_i;
          acc_nxt   = '0;
          rem_nxt   = len_clamp;
          state_nxt = (len_clamp == '0) ? FOLD : ACC;
        end
      end
      ACC: begin
        acc_nxt = acc + {16'h0000, byte_hi, byte_lo};
        ptr_nxt = ptr + ADDR_W'(2);
        rem_nxt = (rem >= REM_W'(2)) ? rem - REM_W'(2) : '0;
        if (rem <= REM_W'(2)) state_nxt = FOLD;
      end
      FOLD: begin
        val_nxt   = fold_cksum(acc);
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      ptr           <= '0;
      rem           <= '0;
      cksum_ready_o <= 1'b0;
      cksum_val_o   <= 16'h0000;
    end else begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      ptr           <= ptr_nxt;
      rem           <= rem_nxt;
      cksum_ready_o <= ready_nxt;
      cksum_val_o   <= val_nxt;
    end
  end

endmodule

// File: tb/tb_hdr_cksum_engine.sv
// -----------------------------------------------------------------------------
// tb_hdr_cksum_engine
//
// Directed bench for hdr_cksum_engine. It uses one header image laid out so
// that every case can share it:
//   bytes  0..2   01 02 03       odd-length span
//   bytes  4..7   FF FF 00 01    end-around carry
//   bytes 14..33  IPv4 header    checksum field at 24..25
//   bytes 62..63  12 34          span running past the buffer end
// -----------------------------------------------------------------------------
module tb_hdr_cksum_engine;

  localparam int HDR_MAX_LEN = 64;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start_i;
  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_i;
  logic [31:0]                 field_start_i;
  logic [31:0]                 field_len_i;
  logic                        cksum_ready_o;
  logic [15:0]                 cksum_val_o;

  int vecs = 0;
  int errs = 0;

  hdr_cksum_engine #(
    .HDR_MAX_LEN (HDR_MAX_LEN),
    .ADDR_W      (32),
    .LEN_W       (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .pkt_hdr_i     (pkt_hdr_i),
    .field_start_i (field_start_i),
    .field_len_i   (field_len_i),
    .cksum_ready_o (cksum_ready_o),
    .cksum_val_o   (cksum_val_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and measure the latency, value and pulse width.
  // clr_idx >= 0 zeroes two header bytes right after the accepting edge,
  // the way the initiator clears the checksum field.
  task automatic do_req(input string tag, input logic [31:0] st, input logic [31:0] ln,
                        input logic [15:0] exp_val, input int exp_edges, input int clr_idx);
    int edges;
    field_start_i = st;
    field_len_i   = ln;
    start_i       = 1'b1;
    step();                                   // E0: accepted
    start_i = 1'b0;
    if (clr_idx >= 0) begin
      pkt_hdr_i[clr_idx]     = 8'h00;
      pkt_hdr_i[clr_idx + 1] = 8'h00;
    end
    check({tag, " rdy_after_accept"}, {31'd0, cksum_ready_o}, 32'd0);
    edges = 0;
    while (edges < 60) begin
      step();
      edges++;
      if (cksum_ready_o) break;
    end
    check({tag, " rdy_seen"}, {31'd0, cksum_ready_o}, 32'd1);
    check({tag, " latency"}, edges, exp_edges);
    check({tag, " value"}, {16'd0, cksum_val_o}, {16'd0, exp_val});
    step();
    check({tag, " pulse_width"}, {31'd0, cksum_ready_o}, 32'd0);
    check({tag, " value_held"}, {16'd0, cksum_val_o}, {16'd0, exp_val});
  endtask

  initial begin
    int pulses;

    rst           = 1'b1;
    start_i       = 1'b0;
    field_start_i = '0;
    field_len_i   = '0;
    pkt_hdr_i     = '0;
    pkt_hdr_i[0] = 8'h01; pkt_hdr_i[1] = 8'h02; pkt_hdr_i[2] = 8'h03;
    pkt_hdr_i[4] = 8'hFF; pkt_hdr_i[5] = 8'hFF; pkt_hdr_i[6] = 8'h00; pkt_hdr_i[7] = 8'h01;
    pkt_hdr_i[14] = 8'h45; pkt_hdr_i[15] = 8'h00; pkt_hdr_i[16] = 8'h00; pkt_hdr_i[17] = 8'h73;
    pkt_hdr_i[18] = 8'h00; pkt_hdr_i[19] = 8'h00; pkt_hdr_i[20] = 8'h40; pkt_hdr_i[21] = 8'h00;
    pkt_hdr_i[22] = 8'h40; pkt_hdr_i[23] = 8'h11; pkt_hdr_i[24] = 8'hB8; pkt_hdr_i[25] = 8'h61;
    pkt_hdr_i[26] = 8'hC0; pkt_hdr_i[27] = 8'hA8; pkt_hdr_i[28] = 8'h00; pkt_hdr_i[29] = 8'h01;
    pkt_hdr_i[30] = 8'hC0; pkt_hdr_i[31] = 8'hA8; pkt_hdr_i[32] = 8'h00; pkt_hdr_i[33] = 8'hC7;
    pkt_hdr_i[62] = 8'h12; pkt_hdr_i[63] = 8'h34;

    // Reset state
    #1;
    check("reset ready", {31'd0, cksum_ready_o}, 32'd0);
    check("reset val", {16'd0, cksum_val_o}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // IPv4 header. A stale checksum field is cleared just after start.
    do_req("ipv4", 32'd14, 32'd20, 16'hB861, 11, 24);
    // Odd length, pad byte zero
    do_req("odd3", 32'd0, 32'd3, 16'hFBFD, 3, -1);
    // Zero length
    do_req("len0", 32'd0, 32'd0, 16'hFFFF, 1, -1);
    // End-around carry
    do_req("carry", 32'd4, 32'd4, 16'hFFFE, 3, -1);
    // Span runs past the buffer end
    do_req("overrun", 32'd62, 32'd4, 16'hEDCB, 3, -1);
    // Length clamped to the whole buffer: 32 words plus the fold
    do_req("clamp", 32'd0, 32'd1000, 16'hA22A, 33, -1);

    // Reset during ACC aborts, with no pulse
    pkt_hdr_i[24] = 8'hB8; pkt_hdr_i[25] = 8'h61;
    field_start_i = 32'd14;
    field_len_i   = 32'd20;
    start_i       = 1'b1;
    step();
    start_i = 1'b0;
    pkt_hdr_i[24] = 8'h00; pkt_hdr_i[25] = 8'h00;
    for (int i = 0; i < 4; i++) step();
    #2 rst = 1'b1;
    #1;
    check("midrst ready", {31'd0, cksum_ready_o}, 32'd0);
    check("midrst val", {16'd0, cksum_val_o}, 32'd0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cksum_ready_o) pulses++;
    end
    check("midrst no_pulse", pulses, 0);
    pkt_hdr_i[24] = 8'hB8; pkt_hdr_i[25] = 8'h61;
    do_req("after_rst", 32'd14, 32'd20, 16'hB861, 11, 24);

    // Back-to-back requests with start_i held high
    field_start_i = 32'd0;
    field_len_i   = 32'd3;
    start_i       = 1'b1;
    step();                                   // first acceptance
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 4) start_i = 1'b0;             // second acceptance happened on edge 4
      if (cksum_ready_o) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b first edge", n, 3);
          check("b2b first val", {16'd0, cksum_val_o}, 32'h0000FBFD);
          field_start_i = 32'd4;
          field_len_i   = 32'd4;
        end else if (pulses == 2) begin
          check("b2b second edge", n, 7);
          check("b2b second val", {16'd0, cksum_val_o}, 32'h0000FFFE);
        end
      end
    end
    check("b2b pulse count", pulses, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
